// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory path: default widths, requester
// port identifiers and the tag carried through the read-return pipe.
package riscv_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Requester identifiers; a single bit is enough to name either port.
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  // Deepest memory read latency the return pipe is built to track.
  localparam int RD_LAT_MAX = 4;

  // One slot of the read-return pipe: valid marks a read in flight,
  // id names the port that issued it.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  // Under contention the port that did not win last time goes next.
  function automatic logic rr_winner(input logic last_gnt);
    return ~last_gnt;
  endfunction

endpackage : riscv_pkg

// File: rtl/rd_return_pipe.sv
// Fixed-latency shift of read tags. A tag pushed in the grant cycle appears
// at the output exactly RD_LAT cycles later, when the memory presents the
// matching read data. Clearing is asynchronous so reads in flight at reset
// are dropped and never produce a return pulse.
module rd_return_pipe
  import riscv_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic push_valid,
  input  logic push_id,
  output logic pop_valid,
  output logic pop_id
);

  // Only latencies the rest of the memory path supports are meaningful.
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("rd_return_pipe: RD_LAT out of range");
  end

  rd_tag_t stage [RD_LAT];

  // Shift register: a new tag enters every cycle (writes and idle cycles
  // push an invalid tag), so the pipe can never fill up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].valid <= push_valid;
      stage[0].id    <= push_id;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign pop_valid = stage[RD_LAT-1].valid;
  assign pop_id    = stage[RD_LAT-1].id;

endmodule : rd_return_pipe

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core load/store path
// (port 0) and the loader/debug master (port 1). Round-robin grant, a
// request mux towards the memory, a fixed-latency tag pipe that steers read
// data back to the issuing port, and a saturating count of contended cycles.
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic last_gnt;
  logic pop_valid;
  logic pop_id;
  logic push_valid;
  logic push_id;

  // Grant decision, purely combinational so a lone requester is served in
  // the same cycle it asks. Nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (req0 && req1) begin
        if (rr_winner(last_gnt) == PORT_CORE) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Memory-side mux: the granted port drives the access; with no grant the
  // strobes stay low and port 0's address/data are passed through.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr0;
    mem_wdata = wdata0;
    if (gnt0) begin
      mem_en = 1'b1;
      mem_we = we0;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Remember who was served last; starting at port 1 lets port 0 win the
  // very first conflict after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= PORT_LOAD;
    end else if (gnt0) begin
      last_gnt <= PORT_CORE;
    end else if (gnt1) begin
      last_gnt <= PORT_LOAD;
    end
  end

  // Count cycles in which both ports want the memory, sticking at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (req0 && req1 && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  assign push_valid = mem_en & ~mem_we;
  assign push_id    = gnt1 ? PORT_LOAD : PORT_CORE;

  rd_return_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_return_pipe (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_id    (push_id),
    .pop_valid  (pop_valid),
    .pop_id     (pop_id)
  );

  assign rvalid0 = pop_valid & (pop_id == PORT_CORE);
  assign rvalid1 = pop_valid & (pop_id == PORT_LOAD);
  assign rdata   = mem_rdata;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a request model issues traffic and
// predicts grants, memory strobes, conflict count and read returns; a
// monitor on the falling edge pops those predictions and compares.
module tb_dmem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int RD_LAT  = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    int          cyc;
    logic        g0;
    logic        g1;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cnt;
  } exp_item_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } rd_item_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  int err_count   = 0;
  int check_count = 0;
  int cyc         = 0;
  bit started     = 0;

  exp_item_t gntq[$];
  rd_item_t  rdq[$];

  // Requester state and reference model state
  logic        p_req   [2];
  logic        p_we    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic [31:0] model_mem [256];
  int          m_last;
  int          m_cnt;

  // Memory device environment
  logic [31:0] env_mem [256];
  logic [31:0] rd_pipe [RD_LAT];

  dmem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .rdata        (rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index, advanced on each rising edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Single-ported memory with RD_LAT-cycle read data
  always @(posedge clk) begin
    if (mem_en && mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? env_mem[mem_addr[7:0]] : 32'hXXXX_XXXX;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic setReq(input int port, input logic we, input logic [31:0] addr, input logic [31:0] data);
    p_req[port]   = 1'b1;
    p_we[port]    = we;
    p_addr[port]  = addr;
    p_wdata[port] = data;
  endtask

  // Drive one cycle of requests and record what the model says must happen
  task automatic applyStimulus(input bit rst_low);
    exp_item_t e;
    rd_item_t  r;
    int        g;
    @(posedge clk);
    #1;
    reset  = rst_low ? 1'b0 : 1'b1;
    req0   = p_req[0];   req1   = p_req[1];
    we0    = p_we[0];    we1    = p_we[1];
    addr0  = p_addr[0];  addr1  = p_addr[1];
    wdata0 = p_wdata[0]; wdata1 = p_wdata[1];
    e.cyc = cyc; e.g0 = 0; e.g1 = 0; e.en = 0; e.we = 0;
    e.addr = p_addr[0]; e.wdata = p_wdata[0];
    if (rst_low) begin
      m_last = 1;
      m_cnt  = 0;
      rdq.delete();
      e.cnt = 0;
    end else begin
      e.cnt = m_cnt;
      g = -1;
      if (p_req[0] && p_req[1]) g = (m_last == 0) ? 1 : 0;
      else if (p_req[0]) g = 0;
      else if (p_req[1]) g = 1;
      if (p_req[0] && p_req[1] && m_cnt < CNT_MAX) m_cnt++;
      if (g >= 0) begin
        e.en = 1; e.we = p_we[g];
        e.addr = p_addr[g]; e.wdata = p_wdata[g];
        e.g0 = (g == 0); e.g1 = (g == 1);
        m_last = g;
        if (p_we[g]) begin
          model_mem[p_addr[g][7:0]] = p_wdata[g];
        end else begin
          r.port = g;
          r.data = model_mem[p_addr[g][7:0]];
          r.due  = cyc + RD_LAT;
          rdq.push_back(r);
        end
        p_req[g] = 1'b0;
      end
    end
    gntq.push_back(e);
  endtask

  // Monitor: compare DUT outputs with queued predictions on the falling edge
  exp_item_t me;
  rd_item_t  mr;
  always @(negedge clk) begin
    if (started) begin
      if (gntq.size() > 0 && gntq[0].cyc == cyc) begin
        me = gntq.pop_front();
        checkOutput("gnt0", 64'(gnt0), 64'(me.g0));
        checkOutput("gnt1", 64'(gnt1), 64'(me.g1));
        checkOutput("mem_en", 64'(mem_en), 64'(me.en));
        checkOutput("mem_we", 64'(mem_we), 64'(me.we));
        checkOutput("mem_addr", 64'(mem_addr), 64'(me.addr));
        checkOutput("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
        checkOutput("conflict_cnt", 64'(conflict_cnt), 64'(me.cnt));
      end
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        mr = rdq.pop_front();
        checkOutput("rvalid0", 64'(rvalid0), 64'(mr.port == 0));
        checkOutput("rvalid1", 64'(rvalid1), 64'(mr.port == 1));
        checkOutput("rdata", 64'(rdata), 64'(mr.data));
      end else begin
        checkOutput("rvalid0_idle", 64'(rvalid0), 64'(0));
        checkOutput("rvalid1_idle", 64'(rvalid1), 64'(0));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", err_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i]   = init_val(i);
      model_mem[i] = init_val(i);
    end
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; p_we[p] = 0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    m_last = 1;
    m_cnt  = 0;
    started = 1;

    $display("[TB] reset held with both ports requesting");
    setReq(0, 0, 32'h10, 0);
    setReq(1, 0, 32'h14, 0);
    repeat (3) applyStimulus(1);

    $display("[TB] continuous contention, then counter saturation");
    for (int i = 0; i < 26; i++) begin
      if (!p_req[0]) setReq(0, 0, 32'h10 + 32'(4 * (i % 8)), 0);
      if (!p_req[1]) setReq(1, 0, 32'h40 + 32'(4 * (i % 8)), 0);
      applyStimulus(0);
    end
    repeat (RD_LAT + 1) applyStimulus(0);

    $display("[TB] port 0 back-to-back reads");
    for (int i = 0; i < 3; i++) begin
      setReq(0, 0, 32'h10, 0);
      applyStimulus(0);
    end
    repeat (RD_LAT + 1) applyStimulus(0);

    $display("[TB] port 1 write then port 0 read of the same word");
    setReq(1, 1, 32'h20, 32'hDEADBEEF);
    applyStimulus(0);
    setReq(0, 0, 32'h20, 0);
    applyStimulus(0);
    repeat (RD_LAT + 1) applyStimulus(0);

    $display("[TB] reset during an outstanding port 1 read");
    setReq(0, 0, 32'h24, 0);
    applyStimulus(0);
    setReq(0, 0, 32'h28, 0);
    setReq(1, 0, 32'h30, 0);
    applyStimulus(0);
    setReq(1, 0, 32'h34, 0);
    applyStimulus(1);
    applyStimulus(0);
    repeat (RD_LAT + 2) applyStimulus(0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] && ($urandom_range(0, 9) < 6)) begin
          setReq(p, 1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
        end
      end
      applyStimulus($urandom_range(0, 59) == 0);
    end

    p_req[0] = 0;
    p_req[1] = 0;
    repeat (RD_LAT + 2) applyStimulus(0);
    @(negedge clk);
    #1;
    checkOutput("read_queue_drained", 64'(rdq.size()), 64'(0));
    checkOutput("grant_queue_drained", 64'(gntq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule : tb_dmem_arbiter
